// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button front end.
// Each channel synchronises its raw input, debounces it with a stability
// window, and produces a clean level, press/release strobes and an
// optional auto-repeat strobe train while the button is held.
`timescale 1ns/1ps

module button_conditioner #(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 15,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] btn_in,
    output logic [NUM_CH-1:0] level,
    output logic [NUM_CH-1:0] press_pulse,
    output logic [NUM_CH-1:0] release_pulse,
    output logic [NUM_CH-1:0] repeat_pulse
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    // The stability counter only needs to reach STABLE_CYCLES-1.
    localparam int SCW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [SCW-1:0] STAB_LAST = SCW'(STABLE_CYCLES - 1);

    // One repeat counter serves both the initial delay and the period.
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RCW  = $clog2(RMAX) + 1;
    localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        logic                   s;
        logic [SCW-1:0]         stab_cnt;
        logic                   lvl;
        logic                   prs;
        logic                   rls;
        logic                   flip;
        logic                   rise;
        logic                   fall;

        // Shift the asynchronous button through the synchroniser chain.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync <= '0;
            end else begin
                sync <= {sync[SYNC_STAGES-2:0], btn_in[i]};
            end
        end

        assign s    = sync[SYNC_STAGES-1];
        assign flip = (s != lvl) && (stab_cnt == STAB_LAST);
        assign rise = flip && !lvl;
        assign fall = flip && lvl;

        // Debounce: count consecutive mismatch cycles, flip the level and
        // strobe press/release once the mismatch has lasted long enough.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                stab_cnt <= '0;
                lvl      <= 1'b0;
                prs      <= 1'b0;
                rls      <= 1'b0;
            end else begin
                prs <= rise;
                rls <= fall;
                if (s == lvl) begin
                    stab_cnt <= '0;
                end else if (flip) begin
                    stab_cnt <= '0;
                    lvl      <= ~lvl;
                end else begin
                    stab_cnt <= stab_cnt + 1'b1;
                end
            end
        end

        assign level[i]         = lvl;
        assign press_pulse[i]   = prs;
        assign release_pulse[i] = rls;

        if (REPEAT_EN != 0) begin : g_rep
            rep_state_t     state;
            rep_state_t     state_next;
            logic [RCW-1:0] rcnt;
            logic [RCW-1:0] rcnt_next;
            logic           rep_q;
            logic           rep_next;

            // Repeat FSM registers; the strobe itself is registered here too.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    state <= IDLE;
                    rcnt  <= '0;
                    rep_q <= 1'b0;
                end else begin
                    state <= state_next;
                    rcnt  <= rcnt_next;
                    rep_q <= rep_next;
                end
            end

            // Next-state logic: the level fall overrides everything so no
            // strobe is emitted in the release cycle.
            always_comb begin
                state_next = state;
                rcnt_next  = rcnt;
                rep_next   = 1'b0;
                if (fall) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (rise) begin
                                state_next = DELAY;
                                rcnt_next  = '0;
                            end
                        end
                        DELAY: begin
                            if (lvl) begin
                                if (rcnt == DELAY_LAST) begin
                                    rep_next   = 1'b1;
                                    rcnt_next  = '0;
                                    state_next = REPEAT;
                                end else begin
                                    rcnt_next = rcnt + 1'b1;
                                end
                            end
                        end
                        REPEAT: begin
                            if (lvl) begin
                                if (rcnt == PERIOD_LAST) begin
                                    rep_next  = 1'b1;
                                    rcnt_next = '0;
                                end else begin
                                    rcnt_next = rcnt + 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_next = IDLE;
                            rcnt_next  = '0;
                        end
                    endcase
                end
            end

            assign repeat_pulse[i] = rep_q;
        end else begin : g_norep
            assign repeat_pulse[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: scoreboard bench for button_conditioner.
// Expected press/release/repeat strobes are queued with their due cycle
// when stimulus is applied and matched against what the DUT produces.
`timescale 1ns/1ps

module tb_button_conditioner;

    localparam int DEB = 16;   // SYNC_STAGES + STABLE_CYCLES - 1
    localparam int RD  = 64;
    localparam int RP  = 16;

    typedef struct {
        int cyc;
        int kind;
        int ch;
    } sb_entry_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] btn_in;
    logic [3:0] level, press, release_p, rep;
    logic [3:0] level2, press2, release2, rep2;

    int         cyc = 0;
    int         checkCount = 0;
    int         errorCount = 0;
    int         rep2Seen = 0;
    logic [3:0] expLevel = '0;
    sb_entry_t  sb[$];
    string      kname[3] = '{"press", "release", "repeat"};

    button_conditioner dut (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
        .level(level), .press_pulse(press),
        .release_pulse(release_p), .repeat_pulse(rep)
    );

    button_conditioner #(.REPEAT_EN(0)) dut_norep (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in),
        .level(level2), .press_pulse(press2),
        .release_pulse(release2), .repeat_pulse(rep2)
    );

    // Free-running clock and cycle index (number of rising edges so far).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void pushEvent(input int c, input int kind, input int ch);
        sb_entry_t e;
        e.cyc  = c;
        e.kind = kind;
        e.ch   = ch;
        sb.push_back(e);
    endfunction

    // Drive masked channels to val; optionally queue the resulting edge strobe.
    task automatic applyStimulus(input logic [3:0] mask, input logic val,
                                 input bit expectEdge);
        for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) begin
                btn_in[ch] = val;
                if (expectEdge) pushEvent(cyc + 1 + DEB, val ? 0 : 1, ch);
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_level"}, 32'(level), 32'd0);
        checkOutput({tag, "_press"}, 32'(press), 32'd0);
        checkOutput({tag, "_release"}, 32'(release_p), 32'd0);
        checkOutput({tag, "_repeat"}, 32'(rep), 32'd0);
        checkOutput({tag, "_level_norep"}, 32'(level2), 32'd0);
    endtask

    // Monitor: model the level from due events and match each strobe to the queue.
    always @(negedge clk) begin
        int         idx;
        logic [3:0] vec;
        if (!reset_n) begin
            expLevel = '0;
        end else begin
            foreach (sb[j]) begin
                if (sb[j].cyc == cyc && sb[j].kind != 2) expLevel[sb[j].ch] = (sb[j].kind == 0);
            end
            checkOutput("level", 32'(level), 32'(expLevel));
            checkOutput("level_norep", 32'(level2), 32'(expLevel));
            for (int k = 0; k < 3; k++) begin
                vec = (k == 0) ? press : (k == 1) ? release_p : rep;
                for (int ch = 0; ch < 4; ch++) begin
                    if (vec[ch]) begin
                        idx = -1;
                        for (int j = 0; j < sb.size(); j++) begin
                            if (idx < 0 && sb[j].kind == k && sb[j].ch == ch) idx = j;
                        end
                        if (idx >= 0) begin
                            checkOutput($sformatf("%s_ch%0d_cycle", kname[k], ch), cyc, sb[idx].cyc);
                            sb.delete(idx);
                        end else begin
                            checkOutput($sformatf("unexpected_%s_ch%0d", kname[k], ch),
                                        32'(vec[ch]), 32'd0);
                        end
                    end
                end
            end
            for (int j = sb.size() - 1; j >= 0; j--) begin
                if (sb[j].cyc < cyc) begin
                    checkOutput($sformatf("missed_%s_ch%0d_cycle", kname[sb[j].kind], sb[j].ch),
                                cyc, sb[j].cyc);
                    sb.delete(j);
                end
            end
            if (rep2 != 4'd0) rep2Seen++;
        end
    end

    // Hard time limit so the bench always terminates.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t;
        btn_in  = 4'd0;
        reset_n = 1'b0;

        // Reset with idle buttons
        #1;
        checkAllZero("reset");
        waitCycles(20);
        checkAllZero("reset_hold");
        reset_n = 1'b1;
        waitCycles(5);

        // Clean press/release on channel 0, too short for repeat
        applyStimulus(4'b0001, 1'b1, 1'b1);
        waitCycles(40);
        applyStimulus(4'b0001, 1'b0, 1'b1);
        waitCycles(25);

        // Bounce on channel 1: ten 3-cycle segments ending low, then a clean hold
        for (int n = 0; n < 10; n++) begin
            btn_in[1] = ~btn_in[1];
            waitCycles(3);
        end
        applyStimulus(4'b0010, 1'b1, 1'b1);
        waitCycles(30);
        applyStimulus(4'b0010, 1'b0, 1'b1);
        waitCycles(25);

        // Auto-repeat on channel 2; release timed so the fall lands on a repeat slot
        t = cyc + 1 + DEB;
        applyStimulus(4'b0100, 1'b1, 1'b1);
        for (int k = 0; k < 8; k++) pushEvent(t + RD + k * RP, 2, 2);
        waitCycles(192);
        applyStimulus(4'b0100, 1'b0, 1'b1);
        waitCycles(25);
        checkOutput("norep_repeat_count", rep2Seen, 32'd0);

        // Reset in the middle of the repeat delay on channel 3
        applyStimulus(4'b1000, 1'b1, 1'b1);
        waitCycles(DEB + 20);
        checkOutput("pre_reset_level3", 32'(level[3]), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        checkAllZero("midreset");
        sb.delete();
        waitCycles(3);
        reset_n = 1'b1;
        t = cyc + 1 + DEB;
        pushEvent(t, 0, 3);
        pushEvent(t + RD, 2, 3);
        pushEvent(t + RD + RP, 2, 3);
        waitCycles(90);
        applyStimulus(4'b1000, 1'b0, 1'b1);
        waitCycles(25);

        // All four channels pressed together; channel 0 released alone first
        applyStimulus(4'b1111, 1'b1, 1'b1);
        waitCycles(20);
        applyStimulus(4'b0001, 1'b0, 1'b1);
        waitCycles(18);
        checkOutput("multi_ch0_released_only", 32'(level), 32'b1110);
        applyStimulus(4'b1110, 1'b0, 1'b1);
        waitCycles(25);

        checkOutput("scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised multi-channel push-button front end that replaces the single-channel chattering eliminator. Per channel it synchronises the raw input, filters bounce with a programmable stability window, and produces a debounced level, one-cycle press and release pulses, and an optional auto-repeat pulse train while the button is held. It sits between the board pushbuttons and the counter/display logic. All outputs are registered.

## Interface
- `NUM_CH`, 4: number of independent button channels.
- `SYNC_STAGES`, 2: synchroniser flip-flop depth, ≥2.
- `STABLE_CYCLES`, 15: consecutive cycles the synchronised input must differ from `level` before `level` flips, ≥1.
- `REPEAT_EN`, 1: 1 enables auto-repeat; 0 ties `repeat_pulse` to 0.
- `REPEAT_DELAY`, 64: cycles from the `level` rise to the first repeat pulse, ≥1.
- `REPEAT_PERIOD`, 16: cycles between later repeat pulses, ≥1.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_in` in NUM_CH: raw asynchronous buttons, 1 = pressed.
- `level` out NUM_CH: debounced button state.
- `press_pulse` out NUM_CH: one-cycle high in the cycle `level` goes 0→1.
- `release_pulse` out NUM_CH: one-cycle high in the cycle `level` goes 1→0.
- `repeat_pulse` out NUM_CH: one-cycle auto-repeat strobe.

## Operation
- Channels are fully independent and identical. No cross-channel interaction.
- Reset: synchroniser flops, `level`, all pulses, stability counters and repeat counters go to 0. Repeat FSM goes to IDLE. Reset applies immediately, including mid-debounce and mid-repeat.
- Synchroniser: `btn_in` shifts through `SYNC_STAGES` flops. Only the last stage (`s`) is used downstream.
- Stability counter: width is clog2(STABLE_CYCLES)+1 bits, unsigned, no wrap.
  - `s == level`: counter clears to 0.
  - `s != level` and counter < STABLE_CYCLES-1: counter increments.
  - `s != level` and counter == STABLE_CYCLES-1: `level` toggles, counter clears, and the matching press or release pulse is registered high for that one cycle.
  - A mismatch shorter than STABLE_CYCLES (glitch or bounce) clears the counter. `level` does not change.
- Repeat FSM per channel (present only when REPEAT_EN=1):
  - States: IDLE, DELAY, REPEAT.
  - IDLE → DELAY on the `level` rise; repeat counter cleared.
  - DELAY: counter increments each cycle `level`=1. When it reaches REPEAT_DELAY, `repeat_pulse`=1 for one cycle, counter clears, FSM → REPEAT.
  - REPEAT: when the counter reaches REPEAT_PERIOD, pulse and clear; stays in REPEAT.
  - Any state → IDLE in the cycle `level` falls. No repeat pulse in that cycle or afterwards.
  - The counter width covers max(REPEAT_DELAY, REPEAT_PERIOD).
- `press_pulse` and `repeat_pulse` are never high together on a channel.
- A button held through reset release produces a normal press after the debounce latency.

## Timing
- Let t0 be the first rising edge at which `btn_in[i]` is sampled in its new value and it stays stable.
- The `level` flip and the press/release pulse are visible after edge t0 + SYNC_STAGES + STABLE_CYCLES − 1. With defaults this is edge t0+16.
- Pulses are exactly 1 cycle wide.
- Let T be the edge where `level` rises. Repeat pulses occur at T+REPEAT_DELAY, then at T+REPEAT_DELAY+k·REPEAT_PERIOD for k≥1, while `level` stays high.
- Simultaneous edges on several channels are each handled in the same cycles, independently.

## Test plan
- Reset with `btn_in`=0: after `reset_n` goes 0, all outputs read 0. Hold 20 cycles: outputs remain 0.
- Clean press, defaults: `btn_in[0]`=1 from t0, held 40 cycles.
  - Expected: `level[0]` and `press_pulse[0]` rise at t0+16; pulse lasts 1 cycle.
  - Expected: no `repeat_pulse`.
  - Release: `release_pulse[0]` is high for 1 cycle, 16 edges after the release sample.
- Bounce: toggle `btn_in[1]` every 3 cycles for 30 cycles, then hold 1.
  - Expected: exactly one `press_pulse[1]`, at hold start +16.
  - Expected: `level[1]` never glitches.
- Auto-repeat: hold `btn_in[2]` for 200 cycles.
  - Expected: `repeat_pulse[2]` at T+64, T+80, T+96 … up to release.
  - Expected: no repeat pulse in the release cycle.
  - Repeat with REPEAT_EN=0: no `repeat_pulse` at all.
- Reset mid-operation: assert `reset_n`=0 during the DELAY state on channel 3 with the button still held.
  - Expected: all outputs 0 immediately.
  - Expected: after reset release, a fresh press at +16 and the first repeat at +64 from that press.
- Multi-channel: all four buttons pressed on the same edge.
  - Expected: four simultaneous `press_pulse` bits at t0+16.
  - Expected: releasing channel 0 alone does not affect channels 1–3.
